// File: rtl/my_reduce_tree_pkg.sv
// Shared types and helpers for the pipelined reduction tree: operator encoding,
// identity values, the 2-input reduction cell and stage-count arithmetic.
package my_reduce_pkg;

   typedef enum logic [1:0] {
      OP_OR  = 2'd0,
      OP_AND = 2'd1,
      OP_XOR = 2'd2,
      OP_NOR = 2'd3
   } op_e;

   typedef enum logic {
      ACC_IDLE = 1'b0,
      ACC_RUN  = 1'b1
   } acc_state_e;

   function automatic logic identity(op_e op);
      return (op == OP_AND);
   endfunction

   // NOR reduces as OR; the inversion is applied once at the output.
   function automatic logic reduce2(op_e op, logic a, logic b);
      case (op)
         OP_AND:  return a & b;
         OP_XOR:  return a ^ b;
         default: return a | b;
      endcase
   endfunction

   function automatic int num_stages(int width, int levels_per_stage);
      int depth;
      depth = 0;
      for (int w = width; w > 1; w = w / 2) depth++;
      return (depth + levels_per_stage - 1) / levels_per_stage;
   endfunction

endpackage

// File: rtl/my_reduce_tree_stage.sv
// One pipeline stage of the reduction tree: LEVELS combinational 2-input levels
// followed by an enable-gated register for partial results, valid and op.
module my_reduce_stage
   import my_reduce_pkg::*;
#(
   parameter int IN_W   = 16,
   parameter int LEVELS = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       en,
   input  logic                       in_valid,
   input  logic [1:0]                 in_op,
   input  logic [IN_W-1:0]            in_vec,
   output logic                       out_valid,
   output logic [1:0]                 out_op,
   output logic [(IN_W>>LEVELS)-1:0]  out_vec
);

   localparam int OUT_W = IN_W >> LEVELS;

   op_e op;
   assign op = op_e'(in_op);

   // Each level halves the vector; level l holds IN_W>>l partial results.
   for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
      logic [(IN_W>>l)-1:0] v;
      if (l == 0) begin : g_leaf
         assign v = in_vec;
      end else begin : g_node
         for (genvar i = 0; i < (IN_W >> l); i++) begin : g_bit
            assign v[i] = reduce2(op, g_lvl[l-1].v[2*i], g_lvl[l-1].v[2*i+1]);
         end
      end
   end

   logic             valid_q, valid_d;
   logic [1:0]       op_q,    op_d;
   logic [OUT_W-1:0] vec_q,   vec_d;

   always_comb begin
      valid_d = valid_q;
      op_d    = op_q;
      vec_d   = vec_q;
      if (en) begin
         valid_d = in_valid;
         op_d    = in_op;
         vec_d   = g_lvl[LEVELS].v;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only; the data
   // registers are reset too so a post-reset output never shows stale bits.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         op_q    <= 2'd0;
         vec_q   <= '0;
      end else begin
         valid_q <= valid_d;
         op_q    <= op_d;
         vec_q   <= vec_d;
      end
   end

   assign out_valid = valid_q;
   assign out_op    = op_q;
   assign out_vec   = vec_q;

endmodule

// File: rtl/my_reduce_tree.sv
// Pipelined WIDTH-to-1 reduction (OR/AND/XOR/NOR) with valid/ready handshake.
// Define MY_REDUCE_ACCUM_EN to add in_last and fold multi-beat bursts into one result.
module my_reduce_tree
   import my_reduce_pkg::*;
#(
   parameter int WIDTH            = 16,
   parameter int LEVELS_PER_STAGE = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_op,
`ifdef MY_REDUCE_ACCUM_EN
   input  logic             in_last,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_data
);

   localparam int K = LEVELS_PER_STAGE;
   localparam int D = $clog2(WIDTH);
   localparam int S = num_stages(WIDTH, K);

   logic adv;
   logic out_valid_q, out_valid_d;
   logic out_data_q,  out_data_d;
   logic [1:0] op_in;

   // A single global advance: the whole pipe moves or the whole pipe holds.
   assign adv      = !out_valid_q | out_ready;
   assign in_ready = adv;

   for (genvar s = 0; s < S; s++) begin : g_stage
      localparam int LV = (s == S - 1) ? D - K * (S - 1) : K;
      localparam int IW = WIDTH >> (K * s);
      logic                  v;
      logic [1:0]            op;
      logic [(IW>>LV)-1:0]   vec;
      if (s == 0) begin : g_first
         my_reduce_stage #(.IN_W(IW), .LEVELS(LV)) u_stage (
            .clk       (clk),
            .reset     (reset),
            .en        (adv),
            .in_valid  (in_valid),
            .in_op     (op_in),
            .in_vec    (in_data),
            .out_valid (v),
            .out_op    (op),
            .out_vec   (vec)
         );
      end else begin : g_next
         my_reduce_stage #(.IN_W(IW), .LEVELS(LV)) u_stage (
            .clk       (clk),
            .reset     (reset),
            .en        (adv),
            .in_valid  (g_stage[s-1].v),
            .in_op     (g_stage[s-1].op),
            .in_vec    (g_stage[s-1].vec),
            .out_valid (v),
            .out_op    (op),
            .out_vec   (vec)
         );
      end
   end

   logic tree_valid;
   logic tree_res;
   op_e  tree_op;

   assign tree_valid = g_stage[S-1].v;
   assign tree_res   = g_stage[S-1].vec;
   assign tree_op    = op_e'(g_stage[S-1].op);

`ifdef MY_REDUCE_ACCUM_EN

   // Input side: the first beat of a burst fixes the op for every later beat,
   // so the tree already reduces middle beats with the burst's operator.
   logic       in_burst_q, in_burst_d;
   logic [1:0] burst_op_q, burst_op_d;
   logic [S-1:0] last_q, last_d;

   assign op_in = in_burst_q ? burst_op_q : in_op;

   always_comb begin
      in_burst_d = in_burst_q;
      burst_op_d = burst_op_q;
      last_d     = last_q;
      if (adv) begin
         last_d[0] = in_last;
         for (int s = 1; s < S; s++) last_d[s] = last_q[s-1];
         if (in_valid) begin
            in_burst_d = !in_last;
            burst_op_d = op_in;
         end
      end
   end

   acc_state_e state_q,  state_d;
   op_e        acc_op_q, acc_op_d;
   logic       acc_q,    acc_d;
   op_e        cur_op;
   logic       merged;

   assign cur_op = (state_q == ACC_IDLE) ? tree_op : acc_op_q;
   assign merged = (state_q == ACC_IDLE) ? tree_res : reduce2(acc_op_q, acc_q, tree_res);

   always_comb begin
      state_d     = state_q;
      acc_op_d    = acc_op_q;
      acc_d       = acc_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      if (adv) begin
         out_valid_d = 1'b0;
         if (tree_valid) begin
            if (last_q[S-1]) begin
               out_valid_d = 1'b1;
               out_data_d  = (cur_op == OP_NOR) ? ~merged : merged;
               acc_d       = identity(cur_op);
               state_d     = ACC_IDLE;
            end else begin
               acc_d       = merged;
               acc_op_d    = cur_op;
               state_d     = ACC_RUN;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         in_burst_q <= 1'b0;
         burst_op_q <= 2'd0;
         last_q     <= '0;
         state_q    <= ACC_IDLE;
         acc_op_q   <= OP_OR;
         acc_q      <= identity(OP_OR);
      end else begin
         in_burst_q <= in_burst_d;
         burst_op_q <= burst_op_d;
         last_q     <= last_d;
         state_q    <= state_d;
         acc_op_q   <= acc_op_d;
         acc_q      <= acc_d;
      end
   end

`else

   assign op_in = in_op;

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      if (adv) begin
         out_valid_d = tree_valid;
         if (tree_valid) out_data_d = (tree_op == OP_NOR) ? ~tree_res : tree_res;
      end
   end

`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_data_q  <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

endmodule

// File: tb/tb_my_reduce_tree.sv
// Scoreboard bench for my_reduce_tree at WIDTH=16 with K=1, 2 and 4; the
// MY_REDUCE_ACCUM_EN build additionally exercises burst accumulation.
module tb_my_reduce_tree;
   import my_reduce_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        in_valid_r, out_ready_r, in_last_r;
   logic [15:0] in_data_r;
   logic [1:0]  in_op_r;
   int          sel;
   int          cyc = 0;

   logic [2:0] iv, orr, ir, ov, od;

   for (genvar k = 0; k < 3; k++) begin : g_hs
      assign iv[k]  = in_valid_r && (sel == k);
      assign orr[k] = (sel == k) ? out_ready_r : 1'b1;
   end

`ifdef MY_REDUCE_ACCUM_EN
   `define TB_LAST .in_last(in_last_r),
`else
   `define TB_LAST
`endif

   my_reduce_tree #(.WIDTH(16), .LEVELS_PER_STAGE(1)) u_k1 (
      .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(in_data_r),
      .in_op(in_op_r), `TB_LAST .out_valid(ov[0]), .out_ready(orr[0]), .out_data(od[0]));
   my_reduce_tree #(.WIDTH(16), .LEVELS_PER_STAGE(2)) u_k2 (
      .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(in_data_r),
      .in_op(in_op_r), `TB_LAST .out_valid(ov[1]), .out_ready(orr[1]), .out_data(od[1]));
   my_reduce_tree #(.WIDTH(16), .LEVELS_PER_STAGE(4)) u_k4 (
      .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(in_data_r),
      .in_op(in_op_r), `TB_LAST .out_valid(ov[2]), .out_ready(orr[2]), .out_data(od[2]));

   typedef struct {
      int   k;
      logic d;
      int   t_acc;
      bit   chk_lat;
   } sb_t;

   sb_t sbq[$];
   int  n_cmp = 0;
   int  n_err = 0;

   // Directed op sweep with hand-computed results.
   logic [15:0] tv_d   [8] = '{16'h0000, 16'h0100, 16'hFFFF, 16'hFFFE,
                               16'h0007, 16'h0003, 16'h0000, 16'h8000};
   logic [1:0]  tv_op  [8] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
   logic        tv_exp [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

   function automatic int lat_of(int k);
      return (k == 0) ? 4 : (k == 1) ? 2 : 1;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: a transfer happens at the next rising edge whenever valid & ready
   // are both high at the falling edge.
   always @(negedge clk) begin
      sb_t e;
      for (int k = 0; k < 3; k++) begin
         if (!reset && ov[k] && orr[k]) begin
            if (sbq.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_out: dut %0d gave %0b, nothing expected", k, od[k]);
            end else begin
               e = sbq.pop_front();
               check("dut_index", k, e.k);
               check("out_data", od[k], e.d);
               if (e.chk_lat) check("latency", cyc - e.t_acc, lat_of(k));
            end
         end
      end
   end

   // Entered and left at 1 time unit after a rising edge.
   task automatic send(int k, logic [15:0] d, logic [1:0] op, bit last, bit push, logic exp, bit lat);
      int waits;
      waits = 0;
      sel = k; in_data_r = d; in_op_r = op; in_last_r = last; in_valid_r = 1'b1;
      #1;
      while (!ir[k]) begin
         @(posedge clk); #2;
         waits++;
         if (waits > 50) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: dut %0d in_ready stuck at 0, expected 1", k);
            break;
         end
      end
      if (push) sbq.push_back('{k, exp, cyc + 1, lat});
      @(posedge clk); #1;
      in_valid_r = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sbq.size() > 0 && n < 100) begin
         @(posedge clk); n++;
      end
      if (sbq.size() > 0) begin
         n_cmp++; n_err++;
         $display("FAIL drain_timeout: %0d results outstanding, expected 0", sbq.size());
         sbq.delete();
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int n;
      reset = 1'b1; in_valid_r = 1'b0; out_ready_r = 1'b1; in_last_r = 1'b1;
      in_data_r = '0; in_op_r = 2'd0; sel = 0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      for (int k = 0; k < 3; k++) begin
         check("reset_out_valid", ov[k], 1'b0);
         check("reset_out_data", od[k], 1'b0);
         check("reset_in_ready", ir[k], 1'b1);
      end

      // Back-to-back op sweep on every K, latency checked on each result.
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 8; i++) begin
            check("in_ready_stream", ir[k], 1'b1);
            send(k, tv_d[i], tv_op[i], 1'b1, 1'b1, tv_exp[i], 1'b1);
         end
         wait_drain();
      end

      // Backpressure on K=1.
      out_ready_r = 1'b0;
      send(0, 16'h0100, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0);
      send(0, 16'h8000, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
      send(0, 16'hFFFF, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0);
      n = 0;
      while (!ov[0] && n < 20) begin
         @(posedge clk); #1; n++;
      end
      for (int c = 0; c < 5; c++) begin
         check("stall_out_valid", ov[0], 1'b1);
         check("stall_out_data", od[0], 1'b1);
         check("stall_in_ready", ir[0], 1'b0);
         @(posedge clk); #1;
      end
      out_ready_r = 1'b1;
      wait_drain();

      // Reset with three beats in flight on K=1.
      send(0, 16'h0001, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      send(0, 16'hFFFF, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
      send(0, 16'h0001, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("midreset_out_valid", ov[0], 1'b0);
      check("midreset_out_data", od[0], 1'b0);
      check("midreset_in_ready", ir[0], 1'b1);
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         check("post_reset_idle", ov[0], 1'b0);
      end
      send(0, 16'h0007, 2'd2, 1'b1, 1'b1, 1'b1, 1'b1);
      wait_drain();

`ifdef MY_REDUCE_ACCUM_EN
      // OR burst -> 1
      send(0, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      send(0, 16'h0010, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      send(0, 16'h0000, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1);
      // AND burst -> 0
      send(0, 16'hFFFF, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      send(0, 16'hFFFE, 2'd1, 1'b1, 1'b1, 1'b0, 1'b1);
      // XOR burst -> 0
      send(0, 16'h0001, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      send(0, 16'h0001, 2'd2, 1'b1, 1'b1, 1'b0, 1'b1);
      // OR burst with AND/XOR on later beats: still OR -> 1
      send(0, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      send(0, 16'h0010, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      send(0, 16'h0000, 2'd2, 1'b1, 1'b1, 1'b1, 1'b1);
      // NOR burst of zeros -> 1
      send(0, 16'h0000, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      send(0, 16'h0000, 2'd3, 1'b1, 1'b1, 1'b1, 1'b1);
      wait_drain();
`endif

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
